// File: rtl/ag32gbd_buffer_scanout.sv
// ag32gbd_buffer_scanout: fetches a frame from the display buffer one edge-triggered read at a time
// and presents the bytes as a valid/ready stream with first/last markers.
module ag32gbd_buffer_scanout #(
    parameter int FRAME_BYTES = 256,
    parameter int REQ_GAP     = 2,
    parameter int TIMEOUT     = 15
) (
    input  logic       sys_clock,
    input  logic       reset,
    input  logic       start_frame,
    output logic       busy,
    output logic       timeout_err,
    output logic       RequestReadBuffer,
    output logic [9:0] BufferReadOffset,
    input  logic [7:0] BufferReadOutput,
    input  logic       BufferReadDataReady,
    output logic [7:0] pix_data,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic       pix_first,
    output logic       pix_last
);
    localparam int GW = $clog2(REQ_GAP + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_GAP, S_REQ, S_WAIT, S_OUT} state_t;

    state_t        state_q, state_d;
    logic [9:0]    off_q, off_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    data_q, data_d;
    logic          seen_q, seen_d, err_q, err_d;
    logic          rdy_q, req_q, valid_q, first_q, last_q, busy_q;

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        gap_d   = gap_q;
        tmo_d   = tmo_q;
        data_d  = data_q;
        seen_d  = seen_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (start_frame) begin
                off_d   = '0;
                gap_d   = '0;
                err_d   = 1'b0;
                state_d = S_GAP;
            end
            S_GAP: begin
                gap_d   = gap_q + GW'(1);
                state_d = (gap_q == GW'(REQ_GAP - 1)) ? S_REQ : S_GAP;
            end
            S_REQ: begin
                seen_d  = 1'b0;
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // a ready that never went low since the request is left over from the previous read
                seen_d = seen_q | ~rdy_q;
                tmo_d  = tmo_q + TW'(1);
                if (seen_q && rdy_q) begin
                    data_d  = BufferReadOutput;
                    state_d = S_OUT;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    data_d  = 8'h00;
                    err_d   = 1'b1;
                    state_d = S_OUT;
                end
            end
            S_OUT: if (valid_q && pix_ready) begin
                off_d   = last_q ? off_q : off_q + 10'd1;
                gap_d   = '0;
                state_d = last_q ? S_IDLE : S_GAP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            off_q   <= '0;
            gap_q   <= '0;
            tmo_q   <= '0;
            data_q  <= '0;
            seen_q  <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            gap_q   <= gap_d;
            tmo_q   <= tmo_d;
            data_q  <= data_d;
            seen_q  <= seen_d;
            err_q   <= err_d;
            rdy_q   <= BufferReadDataReady;
            req_q   <= state_d == S_WAIT;
            valid_q <= state_d == S_OUT;
            first_q <= state_d == S_OUT && off_d == 10'd0;
            last_q  <= state_d == S_OUT && off_d == 10'(FRAME_BYTES - 1);
            busy_q  <= state_d != S_IDLE;
        end
    end

    assign busy              = busy_q;
    assign timeout_err       = err_q;
    assign RequestReadBuffer = req_q;
    assign BufferReadOffset  = off_q;
    assign pix_data          = data_q;
    assign pix_valid         = valid_q;
    assign pix_first         = first_q;
    assign pix_last          = last_q;
endmodule

// File: tb/tb_ag32gbd_buffer_scanout.sv
// tb_ag32gbd_buffer_scanout: frame scanout against a behavioural buffer controller and an expected-stream model.
module tb_ag32gbd_buffer_scanout;
    localparam int N   = 4;
    localparam int GAP = 2;
    localparam int TMO = 15;

    logic       sys_clock = 1'b0;
    logic       reset, start_frame, busy, timeout_err, RequestReadBuffer;
    logic [9:0] BufferReadOffset;
    logic [7:0] BufferReadOutput, pix_data;
    logic       BufferReadDataReady, pix_valid, pix_ready, pix_first, pix_last;

    ag32gbd_buffer_scanout #(.FRAME_BYTES(N), .REQ_GAP(GAP), .TIMEOUT(TMO)) dut (
        .sys_clock(sys_clock), .reset(reset), .start_frame(start_frame), .busy(busy),
        .timeout_err(timeout_err), .RequestReadBuffer(RequestReadBuffer),
        .BufferReadOffset(BufferReadOffset), .BufferReadOutput(BufferReadOutput),
        .BufferReadDataReady(BufferReadDataReady), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_first(pix_first), .pix_last(pix_last)
    );

    always #5 sys_clock = ~sys_clock;

    logic [7:0] mem [N];
    int lat = 2, fall_dly = 0, hang_off = -1;

    // Buffer controller: stale-high ready, drops after fall_dly, rises with data after lat.
    initial begin
        bit c_prev;
        int o;
        c_prev = 1'b0;
        BufferReadDataReady = 1'b1;
        BufferReadOutput = 8'h00;
        forever begin
            @(negedge sys_clock);
            if (RequestReadBuffer && !c_prev) begin
                o = int'(BufferReadOffset);
                repeat (fall_dly) @(negedge sys_clock);
                BufferReadDataReady = 1'b0;
                repeat (lat) @(negedge sys_clock);
                if (o != hang_off) begin
                    BufferReadOutput = mem[o];
                    BufferReadDataReady = 1'b1;
                end
            end
            c_prev = RequestReadBuffer;
        end
    end

    int vectors = 0, miscompares = 0;
    logic [9:0] got [$];
    int edges, min_low, low_run = 0, stab_err, bp_cnt, bp_bad, busy_after_last;
    bit tprev = 1'b0, last_hs, pv = 1'b0, pr = 1'b0;
    logic [9:0] pd;

    task automatic tick(input int mode, input bit st);
        bit r;
        @(negedge sys_clock);
        start_frame = st;
        if (pv && !pr && (!pix_valid || {pix_first, pix_last, pix_data} != pd)) stab_err++;
        if (last_hs) begin
            busy_after_last = int'(busy);
            last_hs = 1'b0;
        end
        if (RequestReadBuffer && !tprev) begin
            edges++;
            if (low_run < min_low) min_low = low_run;
            low_run = 0;
        end else if (!RequestReadBuffer) low_run++;
        tprev = RequestReadBuffer;
        r = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (mode == 2 && pix_valid && got.size() == 2 && bp_cnt < 5) begin
            r = 1'b0;
            bp_cnt++;
            if (pix_data != mem[2] || RequestReadBuffer) bp_bad++;
        end
        pix_ready = r;
        if (pix_valid && r) begin
            got.push_back({pix_first, pix_last, pix_data});
            if (pix_last) last_hs = 1'b1;
        end
        pv = pix_valid;
        pr = r;
        pd = {pix_first, pix_last, pix_data};
    endtask

    task automatic run_frame(input int mode, input bit st_busy, output int cyc);
        got.delete();
        edges = 0;
        min_low = 1000;
        stab_err = 0;
        bp_cnt = 0;
        bp_bad = 0;
        last_hs = 1'b0;
        busy_after_last = -1;
        tick(mode, 1'b1);
        cyc = 0;
        do begin
            tick(mode, st_busy && (got.size() == 1 || got.size() == 2));
            cyc++;
        end while (busy && cyc < 400);
        vectors++;
        if (cyc >= 400) begin
            miscompares++;
            $display("FAIL frame_done: busy still %0b after %0d cycles, required 0", busy, cyc);
        end
    endtask

    task automatic check_frame(input int hang, input string nm);
        logic [9:0] e;
        vectors++;
        if (got.size() != N) begin
            miscompares++;
            $display("FAIL %s_len: got %0d bytes, expected %0d", nm, got.size(), N);
        end
        for (int i = 0; i < N && i < got.size(); i++) begin
            e = {1'(i == 0), 1'(i == N - 1), (i == hang) ? 8'h00 : mem[i]};
            vectors++;
            if (got[i] !== e) begin
                miscompares++;
                $display("FAIL %s_byte%0d: got {first,last,data}=%h expected %h", nm, i, got[i], e);
            end
        end
        vectors++;
        if (edges != N || min_low < GAP) begin
            miscompares++;
            $display("FAIL %s_req: %0d edges min_low %0d, expected %0d edges min_low>=%0d", nm, edges, min_low, N, GAP);
        end
        vectors++;
        if (stab_err != 0) begin
            miscompares++;
            $display("FAIL %s_stable: %0d valid/ready violations, expected 0", nm, stab_err);
        end
        vectors++;
        if (busy_after_last != 0) begin
            miscompares++;
            $display("FAIL %s_busy_end: busy after last = %0d, expected 0", nm, busy_after_last);
        end
        vectors++;
        if (timeout_err !== 1'(hang >= 0)) begin
            miscompares++;
            $display("FAIL %s_err: timeout_err %0b, expected %0b", nm, timeout_err, hang >= 0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick(0, 1'b0);
        vectors++;
        if ({busy, timeout_err, RequestReadBuffer, BufferReadOffset, pix_data, pix_valid, pix_first, pix_last} !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 0", {busy, timeout_err, RequestReadBuffer, BufferReadOffset, pix_data, pix_valid, pix_first, pix_last});
        end
        reset = 1'b0;
        repeat (2) tick(0, 1'b0);
    endtask

    task automatic test_single_frame();
        int cyc;
        for (int i = 0; i < N; i++) mem[i] = 8'h10 + 8'(i);
        run_frame(0, 1'b0, cyc);
        check_frame(-1, "single");
        vectors++;
        if (cyc > N * (GAP + 7) + 2) begin
            miscompares++;
            $display("FAIL single_rate: %0d cycles, expected <= %0d", cyc, N * (GAP + 7) + 2);
        end
    endtask

    task automatic test_stale_ready();
        int cyc;
        for (int i = 0; i < N; i++) mem[i] = 8'h20 + 8'(i);
        fall_dly = 3;
        run_frame(0, 1'b0, cyc);
        check_frame(-1, "stale");
        fall_dly = 0;
    endtask

    task automatic test_backpressure();
        int cyc;
        for (int i = 0; i < N; i++) mem[i] = 8'h10 + 8'(i);
        run_frame(2, 1'b0, cyc);
        check_frame(-1, "backpressure");
        vectors++;
        if (bp_cnt != 5 || bp_bad != 0) begin
            miscompares++;
            $display("FAIL backpressure_hold: %0d held cycles %0d bad, expected 5 and 0", bp_cnt, bp_bad);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        hang_off = 1;
        run_frame(0, 1'b0, cyc);
        check_frame(1, "timeout");
        repeat (3) tick(0, 1'b0);
        vectors++;
        if (timeout_err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_sticky: timeout_err %0b, expected 1", timeout_err);
        end
        hang_off = -1;
        tick(0, 1'b1);
        tick(0, 1'b0);
        vectors++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_clear: err %0b busy %0b, expected 0 and 1", timeout_err, busy);
        end
        for (int c = 0; c < 400 && busy; c++) tick(0, 1'b0);
    endtask

    task automatic test_start_while_busy();
        int cyc;
        for (int i = 0; i < N; i++) mem[i] = 8'h40 + 8'(i);
        run_frame(0, 1'b1, cyc);
        check_frame(-1, "start_busy");
        repeat (5) tick(0, 1'b0);
        vectors++;
        if (busy !== 1'b0 || edges != N) begin
            miscompares++;
            $display("FAIL start_busy_idle: busy %0b edges %0d, expected 0 and %0d", busy, edges, N);
        end
    endtask

    task automatic test_reset_mid_frame();
        int cyc, n;
        for (int i = 0; i < N; i++) mem[i] = 8'h10 + 8'(i);
        got.delete();
        tick(0, 1'b1);
        cyc = 0;
        do begin
            tick(0, 1'b0);
            cyc++;
        end while (!(RequestReadBuffer && BufferReadOffset == 10'd2) && cyc < 400);
        reset = 1'b1;
        tick(0, 1'b0);
        vectors++;
        if ({busy, timeout_err, RequestReadBuffer, BufferReadOffset, pix_data, pix_valid, pix_first, pix_last} !== 24'h0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got %h expected 0", {busy, timeout_err, RequestReadBuffer, BufferReadOffset, pix_data, pix_valid, pix_first, pix_last});
        end
        reset = 1'b0;
        n = got.size();
        repeat (20) tick(0, 1'b0);
        vectors++;
        if (got.size() != n || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_quiet: %0d bytes after reset busy %0b, expected 0 and 0", got.size() - n, busy);
        end
        run_frame(0, 1'b0, cyc);
        check_frame(-1, "midreset_restart");
    endtask

    task automatic test_random();
        int cyc, hang;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
            lat = $urandom_range(1, 4);
            fall_dly = $urandom_range(0, 3);
            hang = ($urandom_range(0, 2) == 0) ? $urandom_range(0, N - 1) : -1;
            hang_off = hang;
            run_frame(1, 1'b0, cyc);
            check_frame(hang, "random");
        end
        hang_off = -1;
        lat = 2;
        fall_dly = 0;
    endtask

    initial begin
        reset = 1'b1;
        start_frame = 1'b0;
        pix_ready = 1'b1;
        test_reset();
        test_single_frame();
        test_stale_ready();
        test_backpressure();
        test_timeout();
        test_start_while_busy();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ag32gbd_buffer_scanout.md
Name: ag32gbd_buffer_scanout

Overview:
- Read-side initiator for the frame buffer BRAM controller's buffer read port.
- On a frame start it fetches FRAME_BYTES bytes from the current display buffer, offsets 0..FRAME_BYTES-1, one edge-triggered read request at a time.
- Bytes are presented downstream as a valid/ready byte stream with first/last markers.
- Sits between the buffer controller and the pixel output / APF bridge path.

Parameters:
- FRAME_BYTES, 256: bytes per frame. Legal range 1..256 (one buffer half).
- REQ_GAP, 2: minimum cycles RequestReadBuffer is held low before each rising edge. Minimum 2, because the controller detects edges through a 2-flop history.
- TIMEOUT, 15: maximum cycles spent waiting for a read completion before substitution.

Ports:
- sys_clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start_frame  in  1  single-cycle pulse that starts a frame fetch
- busy  out  1  high from frame accept until the last byte handshakes
- timeout_err  out  1  sticky flag; a read completion timed out this frame
- RequestReadBuffer  out  1  read request to the controller; the rising edge triggers the read
- BufferReadOffset  out  10  byte offset within the display buffer; stable while the request is high
- BufferReadOutput  in  8  read data from the controller
- BufferReadDataReady  in  1  controller read-complete level
- pix_data  out  8  output byte
- pix_valid  out  1  output byte valid
- pix_ready  in  1  downstream accept
- pix_first  out  1  qualifies a byte at offset 0
- pix_last  out  1  qualifies a byte at offset FRAME_BYTES-1

Behaviour:
- One clock, sys_clock. Reset is synchronous and active-high, named reset. All outputs are registered.
- Reset values: every output 0, state IDLE, offset counter 0, gap and timeout counters 0.
- Reset mid-frame: same values on the next edge. RequestReadBuffer drops immediately. No partial byte is emitted afterwards.
- BufferReadDataReady is registered once internally (rdy_q) before use.
- States:
  - IDLE: on start_frame, clear offset and timeout_err, set busy, go to GAP. start_frame is ignored whenever busy=1.
  - GAP: hold the request low for REQ_GAP cycles, then go to REQ.
  - REQ: drive RequestReadBuffer=1 with BufferReadOffset=offset, clear seen_low, go to WAIT.
  - WAIT: keep the request high. Set seen_low when rdy_q=0. When seen_low=1 and rdy_q=1, latch BufferReadOutput into pix_data and go to OUT. The stale high ready left over from the previous read must never be accepted.
  - OUT: drive the request low, pix_valid=1, pix_first=(offset==0), pix_last=(offset==FRAME_BYTES-1).
    - On pix_valid&pix_ready with last: go to IDLE and clear busy in the same edge.
    - Otherwise on pix_valid&pix_ready: offset+1, go to GAP.
- Valid/ready rules: pix_data, pix_first and pix_last are stable while pix_valid=1 and pix_ready=0. pix_valid never drops without a handshake. pix_ready may be held high permanently.
- Latency: the byte appears on pix_valid 1 cycle after the qualifying rdy_q rise is sampled.
- Throughput bound with pix_ready=1: at most REQ_GAP+7 cycles per byte.
- Timeout: a counter runs in WAIT and resets on entry to WAIT. When it reaches TIMEOUT:
  - set timeout_err and load pix_data=8'h00;
  - go to OUT, so the frame length is preserved.
- Width rules:
  - offset is 10 bits and never exceeds FRAME_BYTES-1; there is no wrap within a frame.
  - The next frame restarts at 0.
  - The upper offset bits are always 0 for legal FRAME_BYTES.
- Buffer flips are the controller's responsibility. This block never gates on FlipBuffer. A flip mid-frame yields a mixed frame by design.

Test Plan:
- Single frame, FRAME_BYTES=4, controller model returning mem[off]=off+8'h10, pix_ready=1. Required:
  - stream 10,11,12,13;
  - pix_first on 10 only, pix_last on 13 only;
  - busy low the cycle after the 13 handshake;
  - exactly 4 request rising edges, each preceded by at least 2 low cycles.
- Stale ready: model holds BufferReadDataReady=1 and delays the fall by 3 cycles after the edge. Required: no byte is accepted before the fall-then-rise; data equals the newly read value.
- Backpressure: pix_ready=0 for 5 cycles on byte 2. Required: pix_data=12 and pix_valid stay stable; RequestReadBuffer stays low; no new request is issued until the handshake.
- Timeout: the model never completes offset 1. Required:
  - after 15 wait cycles the stream emits 10,00,12,13;
  - timeout_err=1 until the next start_frame, which clears it.
- start_frame pulsed while busy. Required: ignored; the current frame completes unchanged.
- reset asserted in WAIT at offset 2. Required: the next cycle has all outputs 0 and the request low; a following start_frame restarts at offset 0.
